// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file scoreboard.
// Counters saturate at cnt_max(); port k of a packed bus starts at slice_lo(k, width).
package regfile_scoreboard_pkg;

    localparam int DEF_DBITS     = 32;
    localparam int DEF_REGWORDS  = 32;
    localparam int DEF_REGNOBITS = 5;
    localparam int DEF_NUM_RD    = 2;
    localparam int DEF_CNTBITS   = 2;
    localparam int DEF_BYPASS_WB = 1;

    localparam int DEF_CNT_MAX    = (1 << DEF_CNTBITS) - 1;
    localparam int DEF_RD_REGNO_W = DEF_NUM_RD * DEF_REGNOBITS;
    localparam int DEF_RD_DATA_W  = DEF_NUM_RD * DEF_DBITS;

    function automatic int cnt_max(input int cntbits);
        return (1 << cntbits) - 1;
    endfunction

    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_busy_counter.sv
// Pending-writer counter for one architectural register: saturating up/down,
// unchanged on simultaneous inc/dec, flags a decrement seen at zero.
module busy_counter
    import regfile_scoreboard_pkg::*;
#(
    parameter int CNTBITS = DEF_CNTBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [CNTBITS-1:0] cnt_o,
    output logic               nonzero_o,
    output logic               is_max_o,
    output logic               underflow_o
);

    localparam logic [CNTBITS-1:0] CNT_MAX = CNTBITS'(cnt_max(CNTBITS));

    logic [CNTBITS-1:0] cnt_q;
    logic [CNTBITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNTBITS'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNTBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign nonzero_o   = (cnt_q != '0);
    assign is_max_o    = (cnt_q == CNT_MAX);
    // A retire with no outstanding claim is a protocol error even if an issue lands the same cycle.
    assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register pending-writer counters for decode:
// combinational reads with busy flags, issue stall, write-back retire/squash, optional WB bypass.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DBITS     = DEF_DBITS,
    parameter int REGWORDS  = DEF_REGWORDS,
    parameter int REGNOBITS = DEF_REGNOBITS,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int CNTBITS   = DEF_CNTBITS,
    parameter int BYPASS_WB = DEF_BYPASS_WB
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_RD*REGNOBITS-1:0]   rd_regno,
    input  logic [NUM_RD-1:0]             rd_used,
    output logic [NUM_RD*DBITS-1:0]       rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic                          issue_valid,
    input  logic                          issue_wr_reg,
    input  logic [REGNOBITS-1:0]          issue_rd,
    output logic                          stall,
    input  logic                          wb_valid,
    input  logic                          wb_squash,
    input  logic [REGNOBITS-1:0]          wb_regno,
    input  logic [DBITS-1:0]              wb_data,
    output logic                          err_underflow
);

    // Index space padded to 2^REGNOBITS so any index is safe; unused and r0 entries read as idle zero.
    localparam int NPAD = 1 << REGNOBITS;

    logic [NPAD-1:0]    reg_nz;
    logic [NPAD-1:0]    reg_max;
    logic [NPAD-1:0]    reg_uflow;
    logic [CNTBITS-1:0] reg_cnt [NPAD];
    logic [DBITS-1:0]   reg_val [NPAD];

    logic accept;
    logic src_busy;
    logic dest_full;
    logic err_q;

    for (genvar i = 0; i < NPAD; i++) begin : g_reg
        if (i == 0 || i >= REGWORDS) begin : g_zero
            assign reg_nz[i]    = 1'b0;
            assign reg_max[i]   = 1'b0;
            assign reg_uflow[i] = 1'b0;
            assign reg_cnt[i]   = '0;
            assign reg_val[i]   = '0;
        end else begin : g_live
            logic             inc;
            logic             dec;
            logic             wr;
            logic [DBITS-1:0] data_q;

            assign inc = accept && issue_wr_reg && (issue_rd == REGNOBITS'(i));
            assign dec = wb_valid && (wb_regno == REGNOBITS'(i));
            assign wr  = dec && !wb_squash;

            busy_counter #(.CNTBITS(CNTBITS)) u_cnt (
                .clk         (clk),
                .reset       (reset),
                .inc_i       (inc),
                .dec_i       (dec),
                .cnt_o       (reg_cnt[i]),
                .nonzero_o   (reg_nz[i]),
                .is_max_o    (reg_max[i]),
                .underflow_o (reg_uflow[i])
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                end else if (wr) begin
                    data_q <= wb_data;
                end
            end

            assign reg_val[i] = data_q;
        end
    end

    // A non-squash retire hitting the source forwards its data and, if it is the last writer, releases busy.
    always_comb begin
        logic [REGNOBITS-1:0] regno;
        logic                 hit;
        regno   = '0;
        hit     = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            regno = rd_regno[k*REGNOBITS +: REGNOBITS];
            hit   = (BYPASS_WB != 0) && wb_valid && !wb_squash
                    && (wb_regno == regno) && (regno != '0);
            rd_data[k*DBITS +: DBITS] = hit ? wb_data : reg_val[regno];
            rd_busy[k] = reg_nz[regno] && !(hit && (reg_cnt[regno] == CNTBITS'(1)));
        end
    end

    // Issue handshake: the instruction on the issue inputs is accepted in any cycle with
    // issue_valid=1 and stall=0; otherwise decode holds it unchanged and retries next cycle.
    assign src_busy  = |(rd_used & rd_busy);
    assign dest_full = issue_wr_reg && (issue_rd != '0) && reg_max[issue_rd];
    assign stall     = issue_valid && (src_busy || dest_full);
    assign accept    = issue_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (|reg_uflow) begin
            err_q <= 1'b1;
        end
    end

    assign err_underflow = err_q;

endmodule
